// File: rtl/memory_stage.sv
// MEM pipeline stage: registers EX/MEM results, runs word loads/stores over a
// req/ack data-memory handshake, and presents MEM/WB results to writeback.
// A watchdog aborts hung accesses, and misaligned accesses are refused.
module memory_stage #(
  parameter int unsigned DATA      = 32,
  parameter int unsigned REG_WIDTH = 5,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic [DATA-1:0]      alu_o,
  input  logic [DATA-1:0]      wr_data,
  input  logic [REG_WIDTH-1:0] exec_read,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 reg_write,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA-1:0]      mem_addr,
  output logic [DATA-1:0]      mem_wdata,
  input  logic [DATA-1:0]      mem_rdata,
  input  logic                 mem_ack,
  output logic                 wb_valid,
  output logic [REG_WIDTH-1:0] wb_rd,
  output logic [DATA-1:0]      wb_data,
  output logic                 wb_reg_write,
  output logic                 mem_err
);

  localparam int unsigned     CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA-1:0]        addr_q, addr_d;
  logic [DATA-1:0]        wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]   rd_q, rd_d;
  logic                   store_q, store_d;
  logic                   rw_q, rw_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [REG_WIDTH-1:0]   pend_rd_q, pend_rd_d;
  logic [DATA-1:0]        pend_data_q, pend_data_d;
  logic                   pend_rw_q, pend_rw_d;
  logic                   pend_err_q, pend_err_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [REG_WIDTH-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA-1:0]        wb_data_q, wb_data_d;
  logic                   wb_rw_q, wb_rw_d;
  logic                   err_q, err_d;

  logic capture, is_mem, start_access, direct_op, op_rw;

  // Handshake decode: stall follows mem_ack combinationally so the ack cycle can capture.
  always_comb begin
    stall        = (state_q == ACCESS) && !mem_ack;
    capture      = ex_valid && !stall;
    is_mem       = mem_read || mem_write;
    start_access = capture && is_mem && (alu_o[1:0] == 2'b00);
    direct_op    = capture && !(is_mem && (alu_o[1:0] == 2'b00));
    op_rw        = reg_write && !is_mem;
  end

  // Next-state logic. An op taking the direct writeback path while MEM/WB is
  // already claimed this edge (ack edge, or a still-pending op) waits one
  // cycle in the pend_* slot so every instruction gets its own wb_valid cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    store_d      = store_q;
    rw_d         = rw_q;
    pend_valid_d = 1'b0;
    pend_rd_d    = pend_rd_q;
    pend_data_d  = pend_data_q;
    pend_rw_d    = pend_rw_q;
    pend_err_d   = pend_err_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    wb_rw_d      = wb_rw_q;
    err_d        = err_q;

    if (state_q == IDLE) begin
      if (pend_valid_q) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = pend_rd_q;
        wb_data_d  = pend_data_q;
        wb_rw_d    = pend_rw_q;
        if (pend_err_q) err_d = 1'b1;
      end
      if (direct_op) begin
        if (pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_rd_d    = exec_read;
          pend_data_d  = alu_o;
          pend_rw_d    = op_rw;
          pend_err_d   = is_mem;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = exec_read;
          wb_data_d  = alu_o;
          wb_rw_d    = op_rw;
          if (is_mem) err_d = 1'b1;
        end
      end
    end else begin
      if (mem_ack) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = store_q ? addr_q : mem_rdata;
        wb_rw_d    = !store_q && rw_q;
        state_d    = IDLE;
        if (direct_op) begin
          pend_valid_d = 1'b1;
          pend_rd_d    = exec_read;
          pend_data_d  = alu_o;
          pend_rw_d    = op_rw;
          pend_err_d   = is_mem;
        end
      end else if (cnt_q == CNT_LAST) begin
        err_d      = 1'b1;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = '0;
        wb_rw_d    = 1'b0;
        state_d    = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (start_access) begin
      state_d = ACCESS;
      cnt_d   = '0;
      addr_d  = alu_o;
      wdata_d = wr_data;
      rd_d    = exec_read;
      store_d = mem_write;
      rw_d    = reg_write;
    end
  end

  // State and pipeline registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      store_q      <= 1'b0;
      rw_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_data_q  <= '0;
      pend_rw_q    <= 1'b0;
      pend_err_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_rw_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      store_q      <= store_d;
      rw_q         <= rw_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_data_q  <= pend_data_d;
      pend_rw_q    <= pend_rw_d;
      pend_err_q   <= pend_err_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      wb_rw_q      <= wb_rw_d;
      err_q        <= err_d;
    end
  end

  // Output drive from registered state.
  always_comb begin
    mem_req      = (state_q == ACCESS);
    mem_we       = (state_q == ACCESS) && store_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    wb_valid     = wb_valid_q;
    wb_rd        = wb_rd_q;
    wb_data      = wb_data_q;
    wb_reg_write = wb_rw_q;
    mem_err      = err_q;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction-level model.
module tb_memory_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] alu_o = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  exec_read = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        reg_write = 1'b0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        mem_err;

  int vectors = 0;
  int miscompares = 0;

  memory_stage #(.DATA(32), .REG_WIDTH(5), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .alu_o(alu_o),
    .wr_data(wr_data), .exec_read(exec_read), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    mem_ack = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic rw);
    ex_valid  = 1'b1;
    mem_read  = ld;
    mem_write = st;
    alu_o     = a;
    wr_data   = wd;
    exec_read = rd;
    reg_write = rw;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_stall"}, stall, 1'b0);
    chk1({tag, "_req"}, mem_req, 1'b0);
    chk1({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk1({tag, "_wbv"}, wb_valid, 1'b0);
    chk({tag, "_wbrd"}, 32'(wb_rd), 32'h0);
    chk({tag, "_wbdata"}, wb_data, 32'h0);
    chk1({tag, "_wbrw"}, wb_reg_write, 1'b0);
    chk1({tag, "_err"}, mem_err, 1'b0);
  endtask

  // Directed single-instruction vectors, each applied from a fresh reset.
  // req = cycles mem_req is high (ack on the last one), wbc = cycle of wb_valid
  // counted from the capture edge.
  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] alu;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [4:0]  rd;
    logic        rw;
    int          req;
    int          wbc;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic        exp_err;
  } vec_t;

  vec_t tbl [8];

  // Transaction-level reference for the random run.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        err;
  } wb_t;

  wb_t         wbq [$];
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  initial begin
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 5'd5, 1'b1, 0, 1, 32'h0000_0010, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 5'd7, 1'b1, 3, 4, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 5'd3, 1'b1, 1, 2, 32'h0000_0200, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h0, 5'd4, 1'b1, 0, 1, 32'h0000_0102, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0203, 32'h1234, 32'h0, 5'd2, 1'b0, 0, 1, 32'h0000_0203, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, 5'd31, 1'b1, 16, 17, 32'h0BAD_F00D, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd0, 1'b0, 0, 1, 32'hFFFF_FFFC, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'h1234_5678, 5'd9, 1'b0, 2, 3, 32'h1234_5678, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      chk_zero($sformatf("v%0d_rst", i));
      drive_op(tbl[i].ld, tbl[i].st, tbl[i].alu, tbl[i].wdat, tbl[i].rd, tbl[i].rw);
      tick();
      idle_inputs();
      for (int c = 1; c <= tbl[i].wbc + 1; c++) begin
        logic exp_req;
        logic ack;
        exp_req = (c <= tbl[i].req);
        chk1($sformatf("v%0d_c%0d_req", i, c), mem_req, exp_req);
        if (exp_req) begin
          chk($sformatf("v%0d_c%0d_addr", i, c), mem_addr, tbl[i].alu);
          chk1($sformatf("v%0d_c%0d_we", i, c), mem_we, tbl[i].st);
          if (tbl[i].st) chk($sformatf("v%0d_c%0d_wdata", i, c), mem_wdata, tbl[i].wdat);
        end
        ack       = exp_req && (c == tbl[i].req);
        mem_ack   = ack;
        mem_rdata = ack ? tbl[i].rdat : ~tbl[i].rdat;
        #1;
        chk1($sformatf("v%0d_c%0d_stall", i, c), stall, exp_req && !ack);
        chk1($sformatf("v%0d_c%0d_wbv", i, c), wb_valid, c == tbl[i].wbc);
        if (c == tbl[i].wbc) begin
          chk($sformatf("v%0d_wbrd", i), 32'(wb_rd), 32'(tbl[i].rd));
          chk($sformatf("v%0d_wbdata", i), wb_data, tbl[i].exp_data);
          chk1($sformatf("v%0d_wbrw", i), wb_reg_write, tbl[i].exp_rw);
          chk1($sformatf("v%0d_err", i), mem_err, tbl[i].exp_err);
        end
        tick();
      end
      mem_ack = 1'b0;
    end

    // Back-to-back load then store: store captured on the load's ack edge.
    do_reset();
    drive_op(1'b1, 1'b0, 32'h100, 32'h0, 5'd1, 1'b1);
    tick();
    chk1("b2b_c1_req", mem_req, 1'b1);
    chk("b2b_c1_addr", mem_addr, 32'h100);
    chk1("b2b_c1_we", mem_we, 1'b0);
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    drive_op(1'b0, 1'b1, 32'h200, 32'h3333_4444, 5'd2, 1'b1);
    #1;
    chk1("b2b_c1_stall", stall, 1'b0);
    tick();
    idle_inputs();
    chk1("b2b_c2_wbv", wb_valid, 1'b1);
    chk("b2b_c2_wbdata", wb_data, 32'h1111_2222);
    chk("b2b_c2_wbrd", 32'(wb_rd), 32'd1);
    chk1("b2b_c2_wbrw", wb_reg_write, 1'b1);
    chk1("b2b_c2_req", mem_req, 1'b1);
    chk("b2b_c2_addr", mem_addr, 32'h200);
    chk1("b2b_c2_we", mem_we, 1'b1);
    chk("b2b_c2_wdata", mem_wdata, 32'h3333_4444);
    mem_ack = 1'b1;
    mem_rdata = 32'h0;
    #1;
    chk1("b2b_c2_stall", stall, 1'b0);
    tick();
    mem_ack = 1'b0;
    chk1("b2b_c3_wbv", wb_valid, 1'b1);
    chk("b2b_c3_wbdata", wb_data, 32'h200);
    chk("b2b_c3_wbrd", 32'(wb_rd), 32'd2);
    chk1("b2b_c3_wbrw", wb_reg_write, 1'b0);
    chk1("b2b_c3_req", mem_req, 1'b0);

    // Non-memory ops captured on and right after an ack edge write back in order.
    drive_op(1'b1, 1'b0, 32'h300, 32'h0, 5'd3, 1'b1);
    tick();
    chk("pend_c1_addr", mem_addr, 32'h300);
    mem_ack = 1'b1;
    mem_rdata = 32'h77;
    drive_op(1'b0, 1'b0, 32'h55, 32'h0, 5'd9, 1'b1);
    tick();
    mem_ack = 1'b0;
    chk1("pend_c2_wbv", wb_valid, 1'b1);
    chk("pend_c2_wbdata", wb_data, 32'h77);
    chk("pend_c2_wbrd", 32'(wb_rd), 32'd3);
    chk1("pend_c2_req", mem_req, 1'b0);
    drive_op(1'b0, 1'b0, 32'h66, 32'h0, 5'd10, 1'b1);
    tick();
    idle_inputs();
    chk1("pend_c3_wbv", wb_valid, 1'b1);
    chk("pend_c3_wbdata", wb_data, 32'h55);
    chk("pend_c3_wbrd", 32'(wb_rd), 32'd9);
    tick();
    chk1("pend_c4_wbv", wb_valid, 1'b1);
    chk("pend_c4_wbdata", wb_data, 32'h66);
    chk("pend_c4_wbrd", 32'(wb_rd), 32'd10);
    tick();
    chk1("pend_c5_wbv", wb_valid, 1'b0);
    chk("pend_c5_hold", wb_data, 32'h66);

    // Timeout: a load that is never acknowledged.
    do_reset();
    drive_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 1'b1);
    tick();
    idle_inputs();
    begin
      int n;
      n = 0;
      while (mem_req && n < 40) begin
        n++;
        chk1("to_stall", stall, 1'b1);
        tick();
      end
      chk("to_req_cycles", 32'(n), 32'd16);
    end
    chk1("to_wbv", wb_valid, 1'b1);
    chk("to_wbdata", wb_data, 32'h0);
    chk1("to_wbrw", wb_reg_write, 1'b0);
    chk1("to_err", mem_err, 1'b1);
    mem_ack = 1'b1;
    #1;
    chk1("to_ack_idle_stall", stall, 1'b0);
    tick();
    mem_ack = 1'b0;
    chk1("to_ack_idle_wbv", wb_valid, 1'b0);
    chk1("to_ack_idle_req", mem_req, 1'b0);
    drive_op(1'b0, 1'b0, 32'h99, 32'h0, 5'd4, 1'b1);
    tick();
    idle_inputs();
    chk1("to_sticky_wbv", wb_valid, 1'b1);
    chk1("to_sticky_err", mem_err, 1'b1);

    // Reset during an access discards it and clears the sticky error.
    drive_op(1'b1, 1'b0, 32'h80, 32'h0, 5'd2, 1'b1);
    tick();
    idle_inputs();
    tick();
    tick();
    chk1("rmid_req_before", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    chk_zero("rmid");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("rmid_after_wbv", wb_valid, 1'b0);
      chk1("rmid_after_req", mem_req, 1'b0);
    end

    // Randomized run against the transaction-level model.
    do_reset();
    begin
      logic        busy;
      logic        ack;
      logic        exp_stall;
      int          wait_n;
      logic        err_seen;
      logic [31:0] cur_addr;
      logic [31:0] cur_wdata;
      logic [4:0]  cur_rd;
      logic        cur_rw;
      logic        cur_st;
      wb_t         e;
      int          kind;
      logic        ld;
      logic        st;
      logic [31:0] a;
      busy = 1'b0;
      wait_n = 0;
      err_seen = 1'b0;
      cur_addr = '0;
      cur_wdata = '0;
      cur_rd = '0;
      cur_rw = 1'b0;
      cur_st = 1'b0;
      for (int cy = 0; cy < 3000; cy++) begin
        chk1("rnd_req", mem_req, busy);
        if (busy) begin
          chk("rnd_addr", mem_addr, cur_addr);
          chk1("rnd_we", mem_we, cur_st);
          if (cur_st) chk("rnd_wdata", mem_wdata, cur_wdata);
        end
        if (wb_valid) begin
          if (wbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rnd_wb_spurious: got wb_valid=1, want no writeback");
          end else begin
            e = wbq.pop_front();
            chk("rnd_wbrd", 32'(wb_rd), 32'(e.rd));
            chk("rnd_wbdata", wb_data, e.data);
            chk1("rnd_wbrw", wb_reg_write, e.rw);
            if (e.err) err_seen = 1'b1;
          end
        end
        chk1("rnd_err", mem_err, err_seen);

        if (busy) begin
          ack = (wait_n == 1);
          if (!ack) wait_n--;
        end else begin
          ack = ($urandom_range(0, 7) == 0);
        end
        mem_ack   = ack;
        mem_rdata = (busy && ack && !cur_st) ? mem_rd(cur_addr) : $urandom();

        if (cy < 2900 && $urandom_range(0, 9) < 6) begin
          kind = int'($urandom_range(0, 9));
          ld = (kind >= 4 && kind < 7);
          st = (kind >= 7);
          if (ld || st) begin
            a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
          end else begin
            a = $urandom();
          end
          drive_op(ld, st, a, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end else begin
          idle_inputs();
        end

        #1;
        exp_stall = busy && !ack;
        chk1("rnd_stall", stall, exp_stall);

        if (busy && ack) begin
          if (cur_st) begin
            mem_model[cur_addr] = cur_wdata;
            wbq.push_back('{cur_rd, cur_addr, 1'b0, 1'b0});
          end else begin
            wbq.push_back('{cur_rd, mem_rd(cur_addr), cur_rw, 1'b0});
          end
          busy = 1'b0;
        end
        if (ex_valid && !exp_stall) begin
          if ((mem_read || mem_write) && alu_o[1:0] == 2'b00) begin
            busy      = 1'b1;
            cur_addr  = alu_o;
            cur_wdata = wr_data;
            cur_rd    = exec_read;
            cur_rw    = reg_write;
            cur_st    = mem_write;
            wait_n    = int'($urandom_range(1, 6));
          end else begin
            wbq.push_back('{exec_read, alu_o, reg_write && !(mem_read || mem_write),
                            mem_read || mem_write});
          end
        end
        tick();
      end
      chk("rnd_drain", 32'(wbq.size()), 32'd0);
      chk1("rnd_idle_end", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
